seven_seg_scanner: RTL and testbench

- Display back-end that sits directly downstream of the vending controller.
- Consumes its two BCD byte outputs (left_display = change/credit, right_display = price) and its one-hot item_dispense.
- Drives a 4-digit, common-anode, multiplexed 7-segment display.
- On each new dispense event it freezes the shown values and blinks them for a fixed window, with a decimal point marking the dispensed item slot.

---
 rtl/seven_seg_scanner_pkg.sv | 31 +++
 rtl/seven_seg_scanner_bcd_to_seg.sv | 32 +++
 rtl/seven_seg_scanner.sv | 159 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the vending display back-end: active-low gfedcba
// segment codes, digit index width and the flash-window state encoding.
package seven_seg_scanner_pkg;

  localparam int IDX_W      = 2;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } flash_state_e;

  // Active-low one-cold anode pattern for digit index k (an[k] low).
  function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// Combinational BCD nibble to active-low gfedcba decoder; non-decimal
// nibbles show a dash, blank_i forces all segments off.
module bcd_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed common-anode display driver for the vending controller,
// with a frozen, blinking flash window after each new dispense event.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_DIV    = 12500000,
  parameter int FLASH_CYCLES = 100000000,
  parameter int BLANK_LZ     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] left_display,
  input  logic [7:0] right_display,
  input  logic [3:0] item_dispense,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam int FL_W  = $clog2(FLASH_CYCLES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLASH_CYCLES - 1);

  logic [PRE_W-1:0] presc_q;
  logic [IDX_W-1:0] idx_q;

  flash_state_e     state_q;
  logic [FL_W-1:0]  flash_cnt_q;
  logic [BLK_W-1:0] blink_cnt_q;
  logic             blink_phase_q;
  logic [7:0]       snap_left_q;
  logic [7:0]       snap_right_q;
  logic [3:0]       snap_item_q;
  logic [3:0]       prev_dispense_q;

  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             start;
  logic             flash_active;
  logic [7:0]       src_left;
  logic [7:0]       src_right;
  logic [3:0]       nibble;
  logic             is_tens;
  logic             blank_digit;

  assign start        = (item_dispense != 4'd0) && (prev_dispense_q == 4'd0);
  assign flash_active = (state_q == ST_FLASH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRE_LAST) begin
      presc_q <= '0;
      idx_q   <= idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Flash window FSM; a fresh start outranks the window-end clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      flash_cnt_q     <= '0;
      blink_cnt_q     <= '0;
      blink_phase_q   <= 1'b0;
      snap_left_q     <= '0;
      snap_right_q    <= '0;
      snap_item_q     <= '0;
      prev_dispense_q <= '0;
    end else begin
      prev_dispense_q <= item_dispense;
      if (start) begin
        state_q       <= ST_FLASH;
        flash_cnt_q   <= FL_LAST;
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
        snap_left_q   <= left_display;
        snap_right_q  <= right_display;
        snap_item_q   <= item_dispense;
      end else begin
        case (state_q)
          ST_FLASH: begin
            if (flash_cnt_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              flash_cnt_q <= flash_cnt_q - 1'b1;
            end
            if (blink_cnt_q == BLK_LAST) begin
              blink_cnt_q   <= '0;
              blink_phase_q <= ~blink_phase_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    src_left  = flash_active ? snap_left_q  : left_display;
    src_right = flash_active ? snap_right_q : right_display;
    nibble    = src_right[3:0];
    is_tens   = 1'b0;
    case (idx_q)
      2'd3: begin nibble = src_left[7:4];  is_tens = 1'b1; end
      2'd2: begin nibble = src_left[3:0];  is_tens = 1'b0; end
      2'd1: begin nibble = src_right[7:4]; is_tens = 1'b1; end
      default: begin nibble = src_right[3:0]; is_tens = 1'b0; end
    endcase
    blank_digit = (BLANK_LZ != 0) && is_tens && (nibble == 4'd0);
  end

  bcd_to_seg u_dec (
    .bcd_i   (nibble),
    .blank_i (blank_digit),
    .seg_o   (seg_d)
  );

  // The blank blink phase only turns off the anodes; the scan keeps running.
  always_comb begin
    an_d = digit_enable(idx_q);
    dp_d = 1'b1;
    if (flash_active && blink_phase_q) begin
      an_d = 4'hF;
    end else if (flash_active && snap_item_q[idx_q]) begin
      dp_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an_q  <= 4'hF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: scan order, decode, blanking, flash
// window, blink, decimal point, retrigger and reset mid-flash.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] left_display = 8'h00;
  logic [7:0] right_display = 8'h00;
  logic [3:0] item_dispense = 4'h0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fl_start = 0;
  bit fl_on = 1'b0;

  // Expected segment code per digit index (0 = right ones .. 3 = left tens).
  logic [6:0] live_seg [4];
  logic [6:0] snap_seg [4];
  logic [3:0] snap_dp;

  seven_seg_scanner #(
    .REFRESH_DIV  (4),
    .BLINK_DIV    (8),
    .FLASH_CYCLES (32),
    .BLANK_LZ     (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .left_display  (left_display),
    .right_display (right_display),
    .item_dispense (item_dispense),
    .an            (an),
    .seg           (seg),
    .dp            (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_an(input string tag, input logic [3:0] exp);
    chk(tag, {4'h0, an}, {4'h0, exp});
  endtask

  task automatic chk_seg(input string tag, input logic [6:0] exp);
    chk(tag, {1'b0, seg}, {1'b0, exp});
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    chk(tag, {7'h0, obs}, {7'h0, exp});
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Expected outputs after edge number cyc, using the window state held before that edge.
  task automatic check_cycle();
    int idx;
    int w;
    bit infl;
    bit vis;
    logic [3:0] ea;
    idx  = ((cyc - 1) / 4) % 4;
    ea   = ~(4'b0001 << idx);
    w    = cyc - fl_start;
    infl = fl_on && (w >= 1) && (w <= 32);
    vis  = (((w - 1) / 8) % 2) == 0;
    if (infl && !vis) begin
      chk_an("blank_an", 4'hF);
      chk_bit("blank_dp", dp, 1'b1);
    end else if (infl) begin
      chk_an("flash_an", ea);
      chk_seg("flash_seg", snap_seg[idx]);
      chk_bit("flash_dp", dp, snap_dp[idx] ? 1'b0 : 1'b1);
    end else begin
      chk_an("scan_an", ea);
      chk_seg("scan_seg", live_seg[idx]);
      chk_bit("scan_dp", dp, 1'b1);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_cycle();
    end
  endtask

  initial begin
    live_seg = '{7'h40, 7'h7F, 7'h40, 7'h7F};
    snap_seg = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
    snap_dp  = 4'h0;

    // 1: reset values, then scan order E,D,B,7 at 4 cycles each
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_an("rst_an", 4'hF);
    chk_seg("rst_seg", 7'h7F);
    chk_bit("rst_dp", dp, 1'b1);
    reset = 1'b1;
    cyc = 0;
    run(16);

    // 2: leading-zero blanking and digit decode
    left_display  = 8'h05;
    right_display = 8'h25;
    live_seg = '{7'h12, 7'h24, 7'h12, 7'h7F};
    run(16);

    // 3: non-decimal nibble shows a dash
    right_display = 8'h3A;
    live_seg = '{7'h3F, 7'h30, 7'h12, 7'h7F};
    run(16);

    // 4: flash window with item 0 held
    left_display  = 8'h10;
    right_display = 8'h15;
    item_dispense = 4'b0001;
    live_seg = '{7'h12, 7'h79, 7'h40, 7'h79};
    step();
    check_cycle();
    fl_on    = 1'b1;
    fl_start = cyc;
    snap_seg = '{7'h12, 7'h79, 7'h40, 7'h79};
    snap_dp  = 4'b0001;
    run(11);
    left_display = 8'h00;
    live_seg = '{7'h12, 7'h79, 7'h40, 7'h7F};
    run(21);
    run(16);

    // 5: new dispense, then retrigger at window cycle 20 on item 2
    item_dispense = 4'b0000;
    run(2);
    item_dispense = 4'b0001;
    step();
    check_cycle();
    fl_start = cyc;
    snap_seg = '{7'h12, 7'h79, 7'h40, 7'h7F};
    snap_dp  = 4'b0001;
    run(18);
    item_dispense = 4'b0000;
    run(1);
    item_dispense = 4'b0100;
    left_display  = 8'h42;
    right_display = 8'h99;
    live_seg = '{7'h10, 7'h10, 7'h24, 7'h19};
    step();
    check_cycle();
    fl_start = cyc;
    snap_seg = '{7'h10, 7'h10, 7'h24, 7'h19};
    snap_dp  = 4'b0100;
    run(34);

    // 6: reset mid-flash, dispense held through release
    item_dispense = 4'b0000;
    run(2);
    item_dispense = 4'b0100;
    step();
    check_cycle();
    fl_start = cyc;
    run(10);
    reset = 1'b0;
    @(negedge clk);
    chk_an("midrst_an", 4'hF);
    chk_seg("midrst_seg", 7'h7F);
    chk_bit("midrst_dp", dp, 1'b1);
    chk_bit("midrst_flash", dut.flash_active, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    fl_on = 1'b0;
    step();
    check_cycle();
    chk_bit("restart_flash", dut.flash_active, 1'b1);
    fl_on    = 1'b1;
    fl_start = cyc;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
